data_mem_access: RTL and testbench
==================================

# data_mem_access

Multicycle data-memory access unit in the MEM stage. It sits between the control fields the main decoder produces for loads and stores and an SRAM-like data bus. The unit does four things:
- checks address alignment;
- issues a single bus transaction with a req/addr_ok/data_ok handshake;
- stalls the pipeline until the transaction completes;
- returns load data extracted and extended according to width and sign.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  MEM-stage instruction is a load/store (data_sram_en).
- mem_wmask  in  4  store width: 4'b1111 word, 4'b0011 half, 4'b0001 byte, 4'b0000 not a store.
- mem_rwidth  in  4  load width, same encoding as mem_wmask; 4'b0000 not a load.
- load_signed  in  1  1 = sign-extend load data, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data (rt), right-aligned.
- flush  in  1  exception/eret flush of the MEM stage.
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle pulse: access completed.
- rdata  out  32  extended load result, valid while done=1.
- adel  out  1  load address error (combinational).
- ades  out  1  store address error (combinational).
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  2'b00 byte, 2'b01 half, 2'b10 word.
- data_addr  out  32  bus address (equals addr, unmodified).
- data_wdata  out  32  replicated store data.
- data_addr_ok  in  1  request accepted.
- data_rdata  in  32  read data.
- data_data_ok  in  1  data phase complete.

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Alignment:
  - word requires addr[1:0]=0; half requires addr[0]=0; byte is always aligned.
  - adel = mem_en & load & misaligned; ades = mem_en & store & misaligned.
  - On a misaligned access no bus request is issued and stall=0.
- go = mem_en & aligned & ~flush.
- IDLE:
  - go -> REQ.
  - On entry to REQ, latch the following: wr, size, addr, replicated wdata, addr[1:0], rwidth, load_signed.
- REQ:
  - data_req=1.
  - Bus outputs come from the latched copies and stay stable until addr_ok.
  - addr_ok -> WAIT.
  - flush before addr_ok -> IDLE (request withdrawn).
- WAIT:
  - data_ok -> DONE, registering rdata from data_rdata.
  - flush -> DRAIN; if data_ok arrives in the same cycle as flush, go to IDLE and discard.
- DONE: done=1 for one cycle, then -> IDLE.
- DRAIN:
  - Waits for data_ok, discards the data, then -> IDLE.
  - No done is produced.
- stall:
  - 1 in IDLE when go.
  - 1 in REQ and WAIT.
  - In DRAIN, stall = mem_en; a new instruction waits until the outstanding response returns.
  - 0 in DONE, and 0 whenever flush=1 in any state other than DRAIN.
- Store data replication:
  - byte -> {4{wdata[7:0]}}
  - half -> {2{wdata[15:0]}}
  - word -> wdata
- Load extraction, using the latched offset o = addr[1:0]:
  - byte: data_rdata[8o+7:8o].
  - half: data_rdata[31:16] if o[1], else data_rdata[15:0].
  - Extend to 32 bits by sign or zero per load_signed.
  - Word is passed through unchanged.
- Stores complete the same way: data_ok -> DONE with done=1; rdata holds its previous value.

## Timing
- Reset (rst=1 at clk edge):
  - state=IDLE; data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
  - done=0, rdata=0, stall=0.
  - Any outstanding bus transaction is abandoned; the bus is reset together with the unit.
- Minimum latency, with addr_ok granted in the first REQ cycle and data_ok one cycle later:

  | Cycle | Event | stall |
  |---|---|---|
  | c0 | IDLE sees go | 1 |
  | c1 | REQ, data_req=1, addr_ok | 1 |
  | c2 | WAIT, data_ok | 1 |
  | c3 | DONE, done=1 | 0 |

  The pipeline advances at the end of c3.
- The bus guarantees data_ok no earlier than the cycle after addr_ok. The unit never samples data_ok in REQ or IDLE.
- Each bus wait cycle adds exactly one cycle to the stall.
- A back-to-back memory instruction seen in the DONE->IDLE cycle starts a new request at IDLE the following cycle.
- At most one outstanding transaction at any time.

## Test plan
- LW addr=0x0000_1000, addr_ok in the first REQ cycle, data_ok 2 cycles later with data 0xDEAD_BEEF:
  - data_req is high for exactly 1 cycle with data_size=2'b10.
  - done pulses once with rdata=0xDEAD_BEEF.
  - stall is high for 4 cycles.
- Loads with data_rdata=0x80FF_7F01:
  - LB addr=...3, signed -> rdata=0xFFFF_FF80.
  - LBU addr=...3 -> 0x0000_0080.
  - LH addr=...2 -> 0xFFFF_80FF.
  - LHU addr=...0 -> 0x0000_7F01.
- SH addr=0x...2, wdata=0x1234_ABCD -> data_wr=1, data_size=2'b01, data_wdata=0xABCD_ABCD, data_addr=0x...2; done after data_ok.
- Misaligned LW addr=0x...2 -> adel=1, stall=0, no data_req. Misaligned SH addr=0x...1 -> ades=1.
- Flush cases:
  - flush during WAIT -> DRAIN.
  - A new LW presented during DRAIN holds stall=1 until data_ok.
  - The first response is discarded with no done; the new request then issues normally.
- Mid-transaction cases:
  - rst asserted in REQ and in WAIT -> all outputs at their reset values next cycle.
  - flush in REQ with addr_ok withheld -> data_req drops next cycle, no done.

Source files
------------

// File: rtl/data_mem_access.sv
// MEM-stage data memory access unit: alignment check, one outstanding
// req/addr_ok/data_ok bus transaction, pipeline stall and load-data extension.
module data_mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wmask,
  input  logic [3:0]  mem_rwidth,
  input  logic        load_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  localparam logic [MW-1:0] W_WORD = 4'b1111;
  localparam logic [MW-1:0] W_HALF = 4'b0011;
  localparam logic [MW-1:0] W_BYTE = 4'b0001;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic          is_load;
  logic          is_store;
  logic [MW-1:0] acc_width;
  logic          misaligned;
  logic          go;
  logic [1:0]    size_c;
  logic [DW-1:0] wdata_rep;

  logic [1:0]    off_q;
  logic [MW-1:0] rwidth_q;
  logic          signed_q;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_ext;

  // Access decode: width, alignment and bus-facing store data.
  always_comb begin
    is_store   = |mem_wmask;
    is_load    = |mem_rwidth;
    acc_width  = is_store ? mem_wmask : mem_rwidth;
    misaligned = ((acc_width == W_WORD) && (addr[1:0] != 2'b00)) ||
                 ((acc_width == W_HALF) && addr[0]);
    size_c     = SZ_BYTE;
    wdata_rep  = {4{wdata[7:0]}};
    if (acc_width == W_WORD) begin
      size_c    = SZ_WORD;
      wdata_rep = wdata;
    end else if (acc_width == W_HALF) begin
      size_c    = SZ_HALF;
      wdata_rep = {2{wdata[15:0]}};
    end
  end

  assign adel = mem_en & is_load & misaligned;
  assign ades = mem_en & is_store & misaligned;
  assign go   = mem_en & ~misaligned & ~flush;

  // Next-state and stall. An addr_ok that coincides with flush still leaves a
  // response in flight, so it is drained rather than dropped.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_REQ;
          stall   = 1'b1;
        end
      end
      S_REQ: begin
        stall = ~flush;
        if (data_addr_ok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall = ~flush;
        if (flush) begin
          state_d = data_data_ok ? S_IDLE : S_DRAIN;
        end else if (data_data_ok) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall = mem_en;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load extraction from the latched byte offset and width.
  always_comb begin
    byte_sel = data_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_ext = data_rdata;
    if (rwidth_q == W_BYTE) begin
      load_ext = {{24{signed_q & byte_sel[7]}}, byte_sel};
    end else if (rwidth_q == W_HALF) begin
      load_ext = {{16{signed_q & half_sel[15]}}, half_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= SZ_BYTE;
      data_addr  <= '0;
      data_wdata <= '0;
      done       <= 1'b0;
      rdata      <= '0;
      off_q      <= 2'b00;
      rwidth_q   <= '0;
      signed_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_req <= (state_d == S_REQ);
      done     <= (state_d == S_DONE);
      if ((state_q == S_IDLE) && go) begin
        data_wr    <= is_store;
        data_size  <= size_c;
        data_addr  <= addr;
        data_wdata <= wdata_rep;
        off_q      <= addr[1:0];
        rwidth_q   <= mem_rwidth;
        signed_q   <= load_signed;
      end
      if ((state_q == S_WAIT) && data_data_ok && !flush && (rwidth_q != '0)) begin
        rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: randomized loads/stores against a bus responder,
// with a scoreboard of expected bus requests and done results.
module tb_data_mem_access;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wmask;
  logic [3:0]  mem_rwidth;
  logic        load_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          n_done_exp = 0;
  int          cfg_ao = 0;
  int          cfg_do = 0;
  logic [31:0] cfg_rdata = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  bus_t        exp_bus[$];
  logic [31:0] exp_done[$];

  // Ops: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
  data_mem_access dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wmask(mem_wmask),
    .mem_rwidth(mem_rwidth), .load_signed(load_signed), .addr(addr),
    .wdata(wdata), .flush(flush), .stall(stall), .done(done), .rdata(rdata),
    .adel(adel), .ades(ades), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] size_of(input int op);
    if (op == 0 || op == 1 || op == 5) return 2'b00;
    if (op == 2 || op == 3 || op == 6) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [3:0] width_of(input int op);
    case (size_of(op))
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_of(input int op, input logic [31:0] wd);
    case (size_of(op))
      2'b00:   return (wd & 32'h0000_00FF) * 32'h0101_0101;
      2'b01:   return (wd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    case (op)
      0, 1: begin
        sh = 8 * int'(a[1:0]);
        v  = (rd >> sh) & 32'h0000_00FF;
        if (op == 0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      2, 3: begin
        sh = a[1] ? 16 : 0;
        v  = (rd >> sh) & 32'h0000_FFFF;
        if (op == 2 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_en = 1'b0; mem_wmask = 4'b0000; mem_rwidth = 4'b0000;
    load_signed = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_op(input int op, input logic [31:0] a, input logic [31:0] wd);
    mem_en      = 1'b1;
    flush       = 1'b0;
    addr        = a;
    wdata       = wd;
    load_signed = (op == 0 || op == 2);
    mem_rwidth  = (op < 5) ? width_of(op) : 4'b0000;
    mem_wmask   = (op >= 5) ? width_of(op) : 4'b0000;
  endtask

  // Record what the bus and the done pulse should show, then present the op.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] wd,
                       input bit expect_done);
    bus_t e;
    e.wr    = (op >= 5);
    e.size  = size_of(op);
    e.addr  = a;
    e.wdata = rep_of(op, wd);
    exp_bus.push_back(e);
    if (expect_done) begin
      if (op < 5) last_rdata = model_load(op, a, cfg_rdata);
      exp_done.push_back(last_rdata);
      n_done_exp++;
    end
    drive_op(op, a, wd);
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input int ao, input int dly, input logic [31:0] rd);
    int st;
    int rq;
    cfg_ao = ao; cfg_do = dly; cfg_rdata = rd;
    issue(op, a, wd, 1'b1);
    st = 0; rq = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) break;
      st++;
      if (data_req) rq++;
    end
    chk("stall_cycles", 32'(st), 32'(ao + dly + 3));
    chk("req_cycles", 32'(rq), 32'(ao + 1));
    step();
    idle_inputs();
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_req"}, 32'(data_req), 32'h0);
    chk({nm, "_wr"}, 32'(data_wr), 32'h0);
    chk({nm, "_size"}, 32'(data_size), 32'h0);
    chk({nm, "_addr"}, data_addr, 32'h0);
    chk({nm, "_wdata"}, data_wdata, 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_rdata"}, rdata, 32'h0);
    chk({nm, "_stall"}, 32'(stall), 32'h0);
  endtask

  // Bus responder: addr_ok after cfg_ao wait cycles, data_ok cfg_do cycles
  // after the cycle following addr_ok; read data is noise outside data_ok.
  task automatic bus_slave();
    int acnt = 0;
    int dcnt = 0;
    bit busy = 1'b0;
    bit waiting = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = $urandom();
      if (rst) begin
        busy = 1'b0; waiting = 1'b0;
      end else if (busy) begin
        if (dcnt == 0) begin
          data_data_ok = 1'b1; data_rdata = cfg_rdata; busy = 1'b0;
        end else dcnt--;
      end else if (data_req) begin
        if (!waiting) begin
          waiting = 1'b1; acnt = cfg_ao;
        end
        if (acnt == 0) begin
          data_addr_ok = 1'b1; busy = 1'b1; waiting = 1'b0; dcnt = cfg_do;
        end else acnt--;
      end else waiting = 1'b0;
    end
  endtask

  task automatic monitor();
    bus_t e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (data_req && data_addr_ok) begin
        if (exp_bus.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_accept: got request at %h expected none", data_addr);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_wr", 32'(data_wr), 32'(e.wr));
          chk("bus_size", 32'(data_size), 32'(e.size));
          chk("bus_addr", data_addr, e.addr);
          if (e.wr) chk("bus_wdata", data_wdata, e.wdata);
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_pulse: got done rdata %h expected no done", rdata);
        end else begin
          r = exp_done.pop_front();
          chk("done_rdata", rdata, r);
        end
      end
    end
  endtask

  initial begin
    int st;
    int rq;
    int d0;
    int op;
    logic [31:0] a;
    rst = 1'b1; addr = 32'h0; wdata = 32'h0;
    idle_inputs();
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    fork
      bus_slave();
      monitor();
    join_none

    step();
    @(negedge clk);
    check_reset("reset");
    step();
    rst = 1'b0;

    // Minimum-latency word load, then the extension cases.
    run_op(4, 32'h0000_1000, 32'h0, 0, 1, 32'hDEAD_BEEF);
    run_op(0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_7F01);
    run_op(1, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_7F01);
    run_op(2, 32'h0000_1002, 32'h0, 0, 0, 32'h80FF_7F01);
    run_op(3, 32'h0000_1000, 32'h0, 0, 0, 32'h80FF_7F01);
    run_op(6, 32'h0000_1002, 32'h1234_ABCD, 1, 0, 32'h0);

    // Randomized mix of widths, offsets and bus delays.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      a  = $urandom() & 32'hFFFF_FFFC;
      if (size_of(op) == 2'b00) a = a + 32'($urandom_range(0, 3));
      else if (size_of(op) == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
      run_op(op, a, $urandom(), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 2) == 0) step();
    end

    // Misaligned accesses raise the exception and never reach the bus.
    drive_op(4, 32'h0000_2002, 32'h0);
    @(negedge clk);
    chk("lw_mis_adel", 32'(adel), 32'h1);
    chk("lw_mis_ades", 32'(ades), 32'h0);
    chk("lw_mis_stall", 32'(stall), 32'h0);
    rq = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      if (data_req) rq++;
    end
    chk("lw_mis_req", 32'(rq), 32'h0);
    step();
    drive_op(6, 32'h0000_2001, 32'h5555_AAAA);
    @(negedge clk);
    chk("sh_mis_ades", 32'(ades), 32'h1);
    chk("sh_mis_adel", 32'(adel), 32'h0);
    chk("sh_mis_stall", 32'(stall), 32'h0);
    step();
    idle_inputs();
    step();

    // Flush in REQ with addr_ok withheld withdraws the request.
    cfg_ao = 5; cfg_do = 0;
    d0 = done_cnt;
    drive_op(4, 32'h0000_2100, 32'h0);
    step();
    flush = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    chk("flush_req_stall", 32'(stall), 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("flush_req_drop", 32'(data_req), 32'h0);
    repeat (6) step();
    @(negedge clk);
    chk("flush_req_nodone", 32'(done_cnt - d0), 32'h0);
    step();

    // Flush in WAIT drains the response; a new load waits behind it.
    cfg_ao = 0; cfg_do = 5; cfg_rdata = 32'h1357_9BDF;
    d0 = done_cnt;
    issue(4, 32'h0000_3000, 32'h0, 1'b0);
    step();
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_stall", 32'(stall), 32'h0);
    step();
    flush = 1'b0; cfg_do = 0;
    issue(4, 32'h0000_3004, 32'h0, 1'b1);
    st = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall) break;
      st++;
    end
    chk("drain_stall_cycles", 32'(st), 32'd8);
    step();
    idle_inputs();
    @(negedge clk);
    chk("drain_done_count", 32'(done_cnt - d0), 32'h1);
    step();

    // Reset while in REQ.
    cfg_ao = 3; cfg_do = 0;
    drive_op(4, 32'h0000_4000, 32'h0);
    step();
    rst = 1'b1; idle_inputs();
    step();
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    check_reset("rst_req");
    step();

    // Reset while in WAIT.
    cfg_ao = 0; cfg_do = 4;
    issue(4, 32'h0000_5000, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b1; idle_inputs();
    step();
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    check_reset("rst_wait");
    step();

    // Normal operation resumes after reset; a store leaves rdata at zero.
    run_op(7, 32'h0000_6000, 32'hCAFE_F00D, 0, 1, 32'h0);
    run_op(5, 32'h0000_6001, 32'h0000_00A5, 0, 0, 32'h0);
    repeat (4) step();

    chk("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
    chk("done_queue_empty", 32'(exp_done.size()), 32'h0);
    chk("done_total", 32'(done_cnt), 32'(n_done_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
